// File: rtl/vga_stream_out.sv
// VGA timing generator fed by a valid/ready pixel stream.
//
// Free-running horizontal/vertical counters produce hsync/vsync/de. Incoming
// pixels go through a small FIFO and are popped one per active pixel once the
// stream has locked to a start-of-frame word. Any underflow or misplaced SOF
// blacks out the rest of the frame, sets the sticky err flag and relocks.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   s_data/s_sof/s_valid  input pixel stream {R,G,B}, SOF marks frame pixel 0
//   s_ready               stream accept (combinational)
//   r/g/b, de             registered pixel colour and data-enable
//   hsync, vsync          registered active-low syncs
//   err                   sticky underflow / SOF misalignment flag
module vga_stream_out #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        err
);

  localparam int unsigned HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW = $clog2(HT + 1);
  localparam int unsigned VW = $clog2(VT + 1);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] HLast    = HW'(HT - 1);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_SYNC);
  localparam logic [HW-1:0] HActLo   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] HActHi   = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] VLast    = VW'(VT - 1);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_SYNC);
  localparam logic [VW-1:0] VActLo   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VActHi   = VW'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {StResync, StArmed, StRun} state_e;

  // Timing counters: free-running, independent of the stream.
  logic [HW-1:0] hcnt_q;
  logic [VW-1:0] vcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (hcnt_q == HLast) begin
      hcnt_q <= '0;
      vcnt_q <= (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_q <= hcnt_q + 1'b1;
    end
  end

  logic active, frame_start;
  assign active = (hcnt_q >= HActLo) && (hcnt_q < HActHi) &&
                  (vcnt_q >= VActLo) && (vcnt_q < VActHi);
  assign frame_start = (hcnt_q == HActLo) && (vcnt_q == VActLo);

  // Pixel FIFO, pointers carry one extra wrap bit to tell full from empty.
  logic [24:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        empty, full;
  logic [24:0] head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head  = mem_q[rptr_q[AW-1:0]];

  state_e      state_q, state_d;
  logic        push, pop, flush;
  logic        err_q, err_d;
  logic [23:0] pix_d, pix_q;
  logic        hsync_q, vsync_q, de_q;

  // Held low during reset; RESYNC always accepts since it discards non-SOF words.
  assign s_ready = rst_n & ((state_q == StResync) | ~full);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    err_d   = err_q;
    pix_d   = '0;
    unique case (state_q)
      StResync: begin
        if (s_valid && s_ready && s_sof) begin
          push    = 1'b1;
          state_d = StArmed;
        end
      end
      StArmed: begin
        push = s_valid && s_ready;
        if (frame_start && !empty) begin
          pop     = 1'b1;
          pix_d   = head[23:0];
          state_d = StRun;
        end
      end
      StRun: begin
        push = s_valid && s_ready;
        if (active) begin
          // SOF flag must be set exactly at the frame start pixel.
          if (empty || (head[24] != frame_start)) begin
            err_d   = 1'b1;
            flush   = 1'b1;
            push    = 1'b0;
            state_d = StResync;
          end else begin
            pop   = 1'b1;
            pix_d = head[23:0];
          end
        end
      end
      default: begin
        flush   = 1'b1;
        state_d = StResync;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= {s_sof, s_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // State and all registered outputs; outputs lag the counters by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StResync;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= (hcnt_q >= HSyncEnd);
      vsync_q <= (vcnt_q >= VSyncEnd);
      de_q    <= active;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end

  assign r     = pix_q[23:16];
  assign g     = pix_q[15:8];
  assign b     = pix_q[7:0];
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign err   = err_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out using a reduced raster (24x13 clocks, 16x8 active)
// so several frames fit in a short run. A queue-based model of the display
// behaviour is compared every clock; per-frame literal totals pin the model.
module tb_vga_stream_out;

  localparam int HS = 3, HB = 3, HA = 16, HF = 2;
  localparam int VS = 2, VB = 2, VA = 8, VF = 1;
  localparam int DEPTH = 4;
  localparam int HT = HS + HB + HA + HF;  // 24
  localparam int VT = VS + VB + VA + VF;  // 13
  localparam int FR = HT * VT;            // 312 clocks per frame
  localparam int NPIX = HA * VA;          // 128 pixels per frame

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] s_data;
  logic        s_sof, s_valid, s_ready;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, de, err;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .de(de), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-frame literal expectations, indexed by frame number since reset; -1 = skip.
  int lit_first [4];
  int lit_err   [4];

  task automatic chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, got, want);
    end
  endtask

  // ---------------- model + compare process ----------------
  typedef enum int {MResync, MArmed, MRun} mstate_e;
  mstate_e     m_st;
  logic [24:0] q[$];
  int          m_h, m_v;
  logic        m_err;
  logic        e_hs, e_vs, e_de, e_err;
  logic [23:0] e_px;
  // frame statistics on DUT outputs
  bit          collecting;
  int          fno, st_de, st_hl, st_vl, st_first;

  task automatic model_reset();
    m_st = MResync; q.delete(); m_h = 0; m_v = 0; m_err = 1'b0;
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_err = 1'b0; e_px = '0;
    collecting = 1'b0; fno = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rgb"}, int'({r, g, b}), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_hsync"}, int'(hsync), 0);
    chk({tag, "_vsync"}, int'(vsync), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
  endtask

  always @(negedge clk or negedge rst_n) begin
    if ($time > 0) begin
      if (clk === 1'b1) begin
        // reset asserted between clock edges: values must appear without a clock
        #1;
        chk_reset_vals("async_rst");
        model_reset();
      end else if (!rst_n) begin
        chk_reset_vals("rst");
        model_reset();
      end else begin
        logic        act, fs, rdy, acc, bad;
        logic [24:0] w;
        logic [23:0] px;
        // outputs now on the pins belong to the previous counter position
        chk("rgb", int'({r, g, b}), int'(e_px));
        chk("de", int'(de), int'(e_de));
        chk("hsync", int'(hsync), int'(e_hs));
        chk("vsync", int'(vsync), int'(e_vs));
        chk("err", int'(err), int'(e_err));

        if (m_h == 1 && m_v == 0) begin
          collecting = 1'b1; st_de = 0; st_hl = 0; st_vl = 0; st_first = -1;
        end
        if (collecting) begin
          if (de) begin
            if (st_first < 0) st_first = int'({r, g, b});
            st_de++;
          end
          if (!hsync) st_hl++;
          if (!vsync) st_vl++;
          if (m_h == 0 && m_v == 0) begin
            chk("frame_de_count", st_de, NPIX);
            chk("frame_hsync_low", st_hl, HS * VT);
            chk("frame_vsync_low", st_vl, VS * HT);
            if (fno < 4 && lit_first[fno] >= 0) chk("frame_first_px", st_first, lit_first[fno]);
            if (fno < 4 && lit_err[fno] >= 0) chk("frame_err", int'(err), lit_err[fno]);
            fno++;
            collecting = 1'b0;
          end
        end

        // model step for the upcoming edge
        act = (m_h >= HS + HB) && (m_h < HS + HB + HA) && (m_v >= VS + VB) && (m_v < VS + VB + VA);
        fs  = (m_h == HS + HB) && (m_v == VS + VB);
        rdy = (m_st == MResync) || (q.size() < DEPTH);
        chk("s_ready", int'(s_ready), int'(rdy));
        acc = s_valid && rdy;
        px  = '0;
        bad = 1'b0;
        case (m_st)
          MResync: begin
            if (acc && s_sof) begin
              q.push_back({s_sof, s_data});
              m_st = MArmed;
            end
          end
          MArmed: begin
            if (fs && q.size() > 0) begin
              w = q.pop_front(); px = w[23:0]; m_st = MRun;
            end
            if (acc) q.push_back({s_sof, s_data});
          end
          default: begin
            if (act) begin
              if (q.size() == 0) bad = 1'b1;
              else begin
                w = q[0];
                if (w[24] != fs) bad = 1'b1;
                else begin
                  w = q.pop_front(); px = w[23:0];
                end
              end
            end
            if (bad) begin
              m_err = 1'b1; q.delete(); m_st = MResync;
            end else if (acc) q.push_back({s_sof, s_data});
          end
        endcase
        e_hs = (m_h >= HS); e_vs = (m_v >= VS); e_de = act; e_px = px; e_err = m_err;
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v + 1) % VT;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int f0, input int f1, input int f2,
                          input int e0, input int e1, input int e2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    lit_first[0] = f0; lit_first[1] = f1; lit_first[2] = f2; lit_first[3] = -1;
    lit_err[0] = e0; lit_err[1] = e1; lit_err[2] = e2; lit_err[3] = -1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive_word(input int j, input int gn, input int xsof);
    if (j > 0) begin
      s_data = 24'hA50000 | 24'(j);
      s_sof = 1'b0;
    end else begin
      s_data = gn[23:0];
      s_sof = ((gn % NPIX) == 0) || (gn == xsof);
    end
  endtask

  // Continuous source: junk words first, then pixel n = n with SOF every frame.
  task automatic stream(input int ncyc, input int junk, input int stall_at,
                        input int stall_len, input int xsof);
    int gn = 0;
    int j = junk;
    int st = 0;
    logic acc;
    s_valid = 1'b1;
    drive_word(j, gn, xsof);
    repeat (ncyc) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        if (j > 0) j--;
        else gn++;
      end
      if (j == 0 && gn == stall_at && st < stall_len) begin
        s_valid = 1'b0;
        st++;
      end else begin
        s_valid = 1'b1;
      end
      drive_word(j, gn, xsof);
    end
  endtask

  initial begin
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    for (int i = 0; i < 4; i++) begin lit_first[i] = -1; lit_err[i] = -1; end

    // no input: black frames, syncs only
    do_reset(0, 0, -1, 0, 0, -1);
    repeat (2 * FR + 5) @(posedge clk);

    // clean stream, 3 frames
    do_reset(0, NPIX, 2 * NPIX, 0, 0, 0);
    stream(3 * FR + 5, 0, -1, 0, -1);

    // 100 junk words before the first SOF
    do_reset(0, NPIX, -1, 0, 0, -1);
    stream(2 * FR + 5, 100, -1, 0, -1);

    // source stall mid-line in frame 1 causes underflow, relock on frame 2
    do_reset(0, NPIX, 2 * NPIX, 0, 1, 1);
    stream(3 * FR + 5, 0, NPIX + 40, 10, -1);

    // stray SOF inside frame 1
    do_reset(0, NPIX, 2 * NPIX, 0, 1, 1);
    stream(3 * FR + 5, 0, -1, 0, NPIX + 60);

    // reset mid-line while running, then a clean restart
    do_reset(0, -1, -1, 0, -1, -1);
    stream(200, 0, -1, 0, -1);
    do_reset(0, NPIX, -1, 0, 0, -1);
    stream(2 * FR + 5, 0, -1, 0, -1);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_stream_out.md
VGA_STREAM_OUT -- requirements
Module: vga_stream_out

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal front porch / sync / back porch in pixel clocks.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-005 Parameter FIFO_DEPTH, default 16, pixel FIFO entries, power of two, at least 4.
REQ-006 clk  input  1  pixel clock, all logic on rising edge; one clock domain.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 s_data  input  24  pixel {R[23:16], G[15:8], B[7:0]}.
REQ-009 s_sof  input  1  marks first pixel of a frame.
REQ-010 s_valid  input  1  s_data/s_sof valid.
REQ-011 s_ready  output  1  word accepted on clk edge when s_valid && s_ready.
REQ-012 r, g, b  output  8 each  pixel colour to the VGA simulator.
REQ-013 hsync, vsync  output  1 each  active-low sync.
REQ-014 de  output  1  high while r/g/b carry an active pixel.
REQ-015 err  output  1  sticky: underflow or SOF misalignment since reset.

Function
REQ-016 hcnt SHALL count 0..HT-1, HT = H_SYNC+H_BP+H_ACTIVE+H_FP (800), then wrap to 0; vcnt SHALL increment when hcnt wraps, counting 0..VT-1, VT = V_SYNC+V_BP+V_ACTIVE+V_FP (525), then wrap to 0.
REQ-017 Region order from count 0: sync, back porch, active, front porch; active pixel iff hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
REQ-018 hsync SHALL be 0 iff hcnt < H_SYNC; vsync SHALL be 0 iff vcnt < V_SYNC.
REQ-019 All outputs except s_ready SHALL be registered; hsync/vsync/de/r/g/b reflect counter state with exactly 1 clk latency, mutually aligned.
REQ-020 Frame start = first active pixel (hcnt = H_SYNC+H_BP, vcnt = V_SYNC+V_BP).
REQ-021 FIFO: FIFO_DEPTH x 25 bits (data+sof); push on s_valid && s_ready; one pop per active pixel in RUN; simultaneous push and pop when full SHALL be rejected for push (s_ready low when full).
REQ-022 States: RESYNC, ARMED, RUN.
REQ-023 RESYNC: FIFO flushed on entry; s_ready=1; words with s_sof=0 accepted and discarded; word with s_sof=1 written to FIFO, next state ARMED.
REQ-024 ARMED: s_ready = !full; no pops; at frame start, if FIFO non-empty go RUN and pop at that pixel, else remain ARMED and output black.
REQ-025 RUN: s_ready = !full; pop one word per active pixel; r/g/b = popped data, de=1.
REQ-026 RUN error conditions: FIFO empty at an active pixel; popped word at frame start has sof=0; popped word at non-frame-start pixel has sof=1.
REQ-027 On error: err set to 1; that pixel and all remaining active pixels of the frame output r=g=b=0 with de=1; state -> RESYNC immediately (sof=1 word that caused error is discarded with the flush).
REQ-028 Outside active pixels r=g=b=0, de=0 in every state; in RESYNC/ARMED active pixels output black with de=1.
REQ-029 Timing counters and sync outputs SHALL free-run independent of state and input stream.

Reset
REQ-030 While rst_n=0: hcnt=vcnt=0, hsync=0, vsync=0, de=0, r=g=b=0, err=0, FIFO empty, state RESYNC, s_ready=0.
REQ-031 After rst_n deasserts, first clk edge SHALL advance hcnt to 1; s_ready=1 (RESYNC) from first cycle out of reset.
REQ-032 Reset asserted mid-frame SHALL immediately force REQ-030 values without waiting for clk.

Verification
REQ-033 Reset, no input, 2 frames -> hsync low 96 of every 800 clks, vsync low 1600 clks of every 420000, de high 640x480 per frame, r=g=b=0, err=0.
REQ-034 Source streams frame where pixel n = n[23:0], sof on n=0, continuous valid -> first frame start shows 0x000000, RUN, de-high pixels match n in order, no err for 3 frames.
REQ-035 Source sends 100 words sof=0 then proper frame -> first 100 discarded, display locks at next frame start, err=0.
REQ-036 Source stalls 50 clks mid-line in RUN -> err=1 at first empty active pixel, black to end of frame, relock on next SOF, err stays 1.
REQ-037 Source inserts extra sof=1 at pixel 1000 -> err=1, black rest of frame, RESYNC.
REQ-038 rst_n pulsed low 3 clks mid-line during RUN -> outputs reach REQ-030 values asynchronously, counters restart at 0, err cleared.
